// File: rtl/seg7_scan3.sv
// rtl/seg7_scan3.sv - three-digit multiplexed 7-segment driver with per-frame snapshot
// Optional leading-zero blanking on the upper two digits: define SEG_LZB_EN.
module seg7_scan3 #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Digit0,
  input  logic [3:0] Digit1,
  input  logic [3:0] Digit2,
  input  logic       DispEn,
  output logic [6:0] Seg,
  output logic [2:0] An,
  output logic       FrameTick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_D0   = 2'd1,
    S_D1   = 2'd2,
    S_D2   = 2'd3
  } state_t;

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [3:0]    snap0_q, snap1_q, snap2_q;
  logic [6:0]    seg_q;
  logic [2:0]    an_q;
  logic          tick_q;

  logic          presc_done;
  logic [6:0]    seg_d0, seg_d1, seg_d2, seg_load;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  assign presc_done = (presc_q == PRESC_LAST);
  assign seg_load   = decode(Digit0);
  assign seg_d0     = decode(snap0_q);

`ifdef SEG_LZB_EN
  // Middle digit blanks only when the whole upper part is zero.
  assign seg_d2 = (snap2_q == 4'd0) ? SEG_BLANK : decode(snap2_q);
  assign seg_d1 = ((snap2_q == 4'd0) && (snap1_q == 4'd0)) ? SEG_BLANK : decode(snap1_q);
`else
  assign seg_d2 = decode(snap2_q);
  assign seg_d1 = decode(snap1_q);
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_LOAD;
      presc_q <= '0;
      snap0_q <= 4'd0;
      snap1_q <= 4'd0;
      snap2_q <= 4'd0;
      seg_q   <= SEG_BLANK;
      an_q    <= 3'b111;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          // Segments come straight from Digit0 since the snapshot is loading on this edge.
          state_q <= S_D0;
          presc_q <= '0;
          snap0_q <= Digit0;
          snap1_q <= Digit1;
          snap2_q <= Digit2;
          seg_q   <= seg_load;
          an_q    <= DispEn ? 3'b110 : 3'b111;
        end
        S_D0: begin
          if (presc_done) begin
            state_q <= S_D1;
            presc_q <= '0;
            seg_q   <= seg_d1;
            an_q    <= DispEn ? 3'b101 : 3'b111;
          end else begin
            presc_q <= presc_q + PW'(1);
            seg_q   <= seg_d0;
            an_q    <= DispEn ? 3'b110 : 3'b111;
          end
        end
        S_D1: begin
          if (presc_done) begin
            state_q <= S_D2;
            presc_q <= '0;
            seg_q   <= seg_d2;
            an_q    <= DispEn ? 3'b011 : 3'b111;
          end else begin
            presc_q <= presc_q + PW'(1);
            seg_q   <= seg_d1;
            an_q    <= DispEn ? 3'b101 : 3'b111;
          end
        end
        default: begin
          if (presc_done) begin
            state_q <= S_LOAD;
            presc_q <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= 3'b111;
            tick_q  <= 1'b1;
          end else begin
            presc_q <= presc_q + PW'(1);
            seg_q   <= seg_d2;
            an_q    <= DispEn ? 3'b011 : 3'b111;
          end
        end
      endcase
    end
  end

  assign Seg       = seg_q;
  assign An        = an_q;
  assign FrameTick = tick_q;

endmodule

// File: tb/tb_seg7_scan3.sv
// tb/tb_seg7_scan3.sv - directed vector bench for seg7_scan3 with SCAN_DIV=4
module tb_seg7_scan3;

  localparam int DIV = 4;
  localparam logic [6:0] SB   = 7'b1111111;
  localparam logic [6:0] SZ   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S8   = 7'b0000000;
  localparam logic [6:0] S9   = 7'b0010000;
  localparam logic [6:0] SDSH = 7'b0111111;
`ifdef SEG_LZB_EN
  localparam logic [6:0] UZ = SB;
`else
  localparam logic [6:0] UZ = SZ;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit0, digit1, digit2;
  logic       disp_en;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] d2, d1, d0;
    logic [6:0] s2, s1, s0;
  } vec_t;
  vec_t vecs[5];

  seg7_scan3 #(.SCAN_DIV(DIV)) dut (
    .Clk(clk), .Reset(rst), .Digit0(digit0), .Digit1(digit1), .Digit2(digit2),
    .DispEn(disp_en), .Seg(seg), .An(an), .FrameTick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Entered at a negedge in S_LOAD (or right after reset release); ends at the next S_LOAD negedge.
  task automatic check_frame(input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0,
                             input int chg_idx, input logic [3:0] chg_val, input int dis_cnt);
    logic [2:0] ea;
    logic [6:0] es;
    if (dis_cnt > 0) disp_en = 1'b0;
    for (int i = 0; i < 3 * DIV; i++) begin
      @(negedge clk);
      if (i < DIV) begin
        ea = 3'b110; es = s0;
      end else if (i < 2 * DIV) begin
        ea = 3'b101; es = s1;
      end else begin
        ea = 3'b011; es = s2;
      end
      if (i < dis_cnt) ea = 3'b111;
      chk("frame_an", 8'(an), 8'(ea));
      chk("frame_seg", 8'(seg), 8'(es));
      chk("frame_tick_low", 8'(frame_tick), 8'd0);
      if (i == chg_idx) digit0 = chg_val;
      if (dis_cnt > 0 && i == dis_cnt - 1) disp_en = 1'b1;
    end
    @(negedge clk);
    chk("load_an", 8'(an), 8'b111);
    chk("load_seg", 8'(seg), 8'(SB));
    chk("load_tick", 8'(frame_tick), 8'd1);
  endtask

  initial begin
    vecs[0] = '{d2: 4'd3, d1: 4'd2,  d0: 4'd1, s2: S3, s1: S2,   s0: S1};
    vecs[1] = '{d2: 4'd0, d1: 4'd12, d0: 4'd9, s2: UZ, s1: SDSH, s0: S9};
    vecs[2] = '{d2: 4'd0, d1: 4'd0,  d0: 4'd5, s2: UZ, s1: UZ,   s0: S5};
    vecs[3] = '{d2: 4'd8, d1: 4'd15, d0: 4'd0, s2: S8, s1: SDSH, s0: SZ};
    vecs[4] = '{d2: 4'd0, d1: 4'd0,  d0: 4'd0, s2: UZ, s1: UZ,   s0: SZ};

    rst = 1'b1;
    disp_en = 1'b1;
    digit2 = 4'd3; digit1 = 4'd2; digit0 = 4'd1;
    repeat (3) @(negedge clk);
    chk("reset_an", 8'(an), 8'b111);
    chk("reset_seg", 8'(seg), 8'(SB));
    chk("reset_tick", 8'(frame_tick), 8'd0);
    rst = 1'b0;

    for (int k = 0; k < 5; k++) begin
      digit2 = vecs[k].d2; digit1 = vecs[k].d1; digit0 = vecs[k].d0;
      check_frame(vecs[k].s2, vecs[k].s1, vecs[k].s0, -1, 4'd0, 0);
    end

    // Digit0 changes mid-S_D1: this frame keeps 1, the next one shows 8.
    digit2 = 4'd3; digit1 = 4'd2; digit0 = 4'd1;
    check_frame(S3, S2, S1, DIV + 1, 4'd8, 0);
    check_frame(S3, S2, S8, -1, 4'd0, 0);

    // Display disabled for 10 cycles, re-enabled inside S_D2 without stretching it.
    check_frame(S3, S2, S8, -1, 4'd0, 10);

    // Asynchronous reset in the middle of S_D1.
    repeat (DIV + 2) @(negedge clk);
    chk("pre_reset_an", 8'(an), 8'b101);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_an", 8'(an), 8'b111);
    chk("async_reset_seg", 8'(seg), 8'(SB));
    chk("async_reset_tick", 8'(frame_tick), 8'd0);
    @(negedge clk);
    chk("held_reset_tick", 8'(frame_tick), 8'd0);
    rst = 1'b0;
    check_frame(S3, S2, S8, -1, 4'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan3.md
# seg7_scan3

Three-digit multiplexed seven-segment display driver that reads the 4-bit digit outputs of the cascaded decimal counter chain and drives one common segment bus plus three digit anodes. It time-multiplexes the digits with a programmable dwell prescaler. It snapshots all three digits once per frame so a counter carry never tears the displayed value. It sits between the counter chain (`Co0`/`Co1`/`Co2`) and the board's display pins.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit is lit; legal range 1 to 2^20; prescaler width is `$clog2(SCAN_DIV)`, minimum 1.
- `Clk`  input  1  system clock; all state changes on the rising edge.
- `Reset`  input  1  asynchronous, active-high reset.
- `Digit0`  input  4  least significant digit, driven by counter C0.
- `Digit1`  input  4  middle digit.
- `Digit2`  input  4  most significant digit.
- `DispEn`  input  1  display enable; low forces all anodes off while scanning continues.
- `Seg`  output  7  segments `{g,f,e,d,c,b,a}`, active-low, registered.
- `An`  output  3  digit anodes, active-low, registered; bit 0 drives Digit0.
- `FrameTick`  output  1  registered one-cycle pulse on the edge entering S_LOAD.

## Operation
- States: S_LOAD, S_D0, S_D1, S_D2.
  - S_LOAD lasts one cycle and always advances to S_D0.
  - S_D0 advances to S_D1, S_D1 to S_D2, and S_D2 to S_LOAD, each when the prescaler reaches `SCAN_DIV-1`.
- Prescaler clears on every state change and counts 0 to `SCAN_DIV-1` inside each digit state.
- Snapshot: on the S_LOAD to S_D0 edge, all three `Digit` inputs are captured into internal registers. Input changes at any other time have no visible effect until the next frame.
- Decode of digit values 0-9 is standard:
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 5 = 0010010
  - 8 = 0000000
- Values 10-15 are invalid BCD and display a dash, 0111111.
- In S_LOAD, `An`=111 and `Seg`=1111111. This one-cycle blank gap between frames suppresses ghosting.
- In S_Dn, `An` has only bit n low, provided `DispEn` is high. `Seg` shows the decoded snapshot digit n.
- When `DispEn` is low, `An` is 111. `Seg` is still decoded normally, and the state and prescaler are unaffected.

## Timing
- Reset values: state S_LOAD, prescaler 0, snapshot 0, `An`=111, `Seg`=1111111, `FrameTick`=0.
- Reset asserted at any time clears all outputs immediately, without waiting for a clock edge.
- First edge after reset release: state becomes S_D0.
  - The snapshot loads from the inputs present at that edge.
  - `An`=110 and `Seg` shows `Digit0` from the same edge; `Seg` is decoded directly from the inputs at that edge.
- `An`, `Seg` and `FrameTick` are registered and update on the same edge as the state transition, so they have zero cycles of lag relative to the state.
- Frame period is `3*SCAN_DIV + 1` cycles.
- `FrameTick` is high for exactly the S_LOAD cycle. It is not asserted for the S_LOAD cycle held during reset.
- `DispEn` is sampled every edge and affects `An` on the following cycle.
- With `SCAN_DIV`=1, each digit is lit for exactly one cycle and the frame is 4 cycles.

## Configuration
- `SEG_LZB_EN` (leading-zero blanking):
  - Defined:
    - A snapshot `Digit2` of 0 displays blank (1111111).
    - `Digit1` also displays blank if both `Digit2` and `Digit1` are 0.
    - `Digit0` is never blanked.
    - Anode timing is unchanged.
  - Undefined: every digit is decoded, so a zero shows 1000000.

## Test plan
- Reset, digits 3/2/1 (`Digit2`/`Digit1`/`Digit0`), `SCAN_DIV`=4, `DispEn`=1 -> expected sequence:
  - `An`=110 with `Seg`=1111001 for 4 cycles.
  - Then `An`=101 with `Seg`=0100100 for 4 cycles.
  - Then `An`=011 with `Seg`=0110000 for 4 cycles.
  - Then 1 cycle of `An`=111 with `FrameTick`=1; repeat.
- Snapshot coherency: change `Digit0` from 1 to 8 during S_D1 -> S_D2 is unchanged; 8 (0000000) appears only in the next frame's S_D0.
- Invalid input: `Digit1`=12 -> `Seg`=0111111 whenever `An`=101.
- Digits 0/0/5:
  - With `SEG_LZB_EN`: S_D2 and S_D1 show 1111111, S_D0 shows 0010010.
  - Without it: S_D2 and S_D1 show 1000000.
  - Digits 0/0/0 with `SEG_LZB_EN`: S_D0 shows 1000000.
- Reset mid-S_D1 -> `An`=111 and `Seg`=1111111 immediately. After release, the next edge enters S_D0 with the prescaler restarted at 0.
- `DispEn`=0 for 10 cycles -> `An`=111 throughout while the state keeps advancing. Re-enabling during S_D2 -> `An`=011 on the next cycle, and the S_D2 dwell is not extended.
